// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multi-cycle MIPS-subset CPU.
// Used by the control FSM, the datapath and the bench so every mux code
// and state number has exactly one definition.
package cpu_ctrl_pkg;

   // Destination register for JAL; the datapath applies it when reg_dst selects REG_DST_JAL.
   localparam logic [4:0] JAL_REG = 5'd31;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;

   // PC source mux
   localparam logic [1:0] PC_SRC_ALU    = 2'd0;  // PC+4 computed this cycle
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;  // branch target latched in DECODE
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;  // {PC[31:28], target, 2'b0}
   localparam logic [1:0] PC_SRC_RS     = 2'd3;  // register jump

   // Register-file destination mux
   localparam logic [1:0] REG_DST_RT  = 2'd0;
   localparam logic [1:0] REG_DST_RD  = 2'd1;
   localparam logic [1:0] REG_DST_JAL = 2'd2;

   // Register-file write data mux
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   // ALU B operand mux
   localparam logic [1:0] SRC_B_RT      = 2'd0;
   localparam logic [1:0] SRC_B_FOUR    = 2'd1;
   localparam logic [1:0] SRC_B_IMM     = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

   // Sequencer states; encodings 14 and 15 are unused.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_R_EXEC   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_I_EXEC   = 4'd8,
      ST_I_WB     = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JUMP     = 4'd11,
      ST_JR       = 4'd12,
      ST_JAL      = 4'd13
   } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// R-type function field decoder: ALU operation, supported flag and JR detect.
// Unsupported codes report valid=0 and leave the ALU on ADD so the datapath
// sees a benign operation while the sequencer raises illegal.
module alu_funct_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       valid,
   output logic       is_jr
);

   // Map funct to ALU code; JR is valid but never executes on the ALU.
   always_comb begin
      alu_ctrl = ALU_ADD;
      valid    = 1'b1;
      is_jr    = 1'b0;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_XOR:  alu_ctrl = ALU_XOR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         FN_JR:   is_jr    = 1'b1;
         default: valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU with one shared
// instruction/data memory. Drives all datapath selects and enables and
// handshakes each memory access so memory can stall the sequence.
module mc_control_fsm
   import cpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_t     state_reg;
   state_t     state_next;
   // High for the cycle after a sampled reset: outputs stay quiet so an
   // access in flight when reset arrived is dropped, not resumed.
   logic       rst_quiet_reg;
   logic [2:0] fn_alu;
   logic       fn_valid;
   logic       fn_is_jr;

   alu_funct_decode u_funct_decode (
      .funct    (funct),
      .alu_ctrl (fn_alu),
      .valid    (fn_valid),
      .is_jr    (fn_is_jr)
   );

   assign state_o = state_reg;

   // State register plus the one-cycle post-reset quiet flag.
   always_ff @(posedge clk) begin
      rst_quiet_reg <= reset;
      if (reset) begin
         state_reg <= ST_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and output decode; every state that does not say otherwise returns to FETCH.
   always_comb begin
      state_next = ST_FETCH;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = M2R_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RT;
      alu_ctrl   = ALU_ADD;
      illegal    = 1'b0;

      if (!rst_quiet_reg) begin
         case (state_reg)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRC_B_FOUR;
               ir_we     = mem_ready;
               pc_we     = mem_ready;
               state_next = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
               // Branch target is computed speculatively for every instruction.
               alu_src_b = SRC_B_IMM_SH2;
               case (opcode)
                  OP_LW, OP_SW:     state_next = ST_MEM_ADDR;
                  OP_RTYPE:         state_next = fn_is_jr ? ST_JR : ST_R_EXEC;
                  OP_ADDI, OP_XORI: state_next = ST_I_EXEC;
                  OP_BEQ, OP_BNE:   state_next = ST_BRANCH;
                  OP_J:             state_next = ST_JUMP;
                  OP_JAL:           state_next = ST_JAL;
                  default:          illegal    = 1'b1;
               endcase
            end
            ST_MEM_ADDR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRC_B_IMM;
               state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
               mem_req    = 1'b1;
               iord       = 1'b1;
               state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            end
            ST_MEM_WB: begin
               reg_write  = 1'b1;
               reg_dst    = REG_DST_RT;
               mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
               mem_req    = 1'b1;
               mem_write  = 1'b1;
               iord       = 1'b1;
               state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            end
            ST_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_RT;
               alu_ctrl  = fn_alu;
               if (fn_valid) begin
                  state_next = ST_R_WB;
               end else begin
                  illegal = 1'b1;
               end
            end
            ST_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = REG_DST_RD;
            end
            ST_I_EXEC: begin
               // XORI zero-extension happens in the datapath immediate path.
               alu_src_a  = 1'b1;
               alu_src_b  = SRC_B_IMM;
               alu_ctrl   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
               state_next = ST_I_WB;
            end
            ST_I_WB: begin
               reg_write = 1'b1;
               reg_dst   = REG_DST_RT;
            end
            ST_BRANCH: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_RT;
               alu_ctrl  = ALU_SUB;
               pc_src    = PC_SRC_ALUOUT;
               pc_we     = (opcode == OP_BNE) ? !zero : zero;
            end
            ST_JUMP: begin
               pc_we  = 1'b1;
               pc_src = PC_SRC_JUMP;
            end
            ST_JR: begin
               pc_we  = 1'b1;
               pc_src = PC_SRC_RS;
            end
            ST_JAL: begin
               // Link value is the already-incremented PC, written before the PC moves.
               pc_we      = 1'b1;
               pc_src     = PC_SRC_JUMP;
               reg_write  = 1'b1;
               reg_dst    = REG_DST_JAL;
               mem_to_reg = M2R_PC;
            end
            default: begin
               state_next = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Each task queues per-cycle stimulus
// and the expected control word, then drains the queues one cycle at a time.
module tb_mc_control_fsm;
   import cpu_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, iord, ir_we, pc_we, reg_write, alu_src_a, illegal;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_ctrl;
   logic [3:0] state_o;

   mc_control_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .iord       (iord),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .illegal    (illegal),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, mem_write, iord, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst, m2r;
      logic       src_a;
      logic [1:0] src_b;
      logic [2:0] alu;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic       rdy;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
   } stim_t;

   out_t  obs;
   out_t  exp_q[$];
   stim_t stim_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [5:0] cur_op, cur_fn;
   logic       cur_z;

   assign obs = {state_o, mem_req, mem_write, iord, ir_we, pc_we, pc_src, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};

   // Expected control words per state, written from the control table.
   function automatic out_t o_st(state_t s);
      out_t o = '0;
      o.st = s;
      return o;
   endfunction
   function automatic out_t o_fetch(logic rdy);
      out_t o = o_st(ST_FETCH);
      o.mem_req = 1'b1; o.src_b = 2'd1; o.ir_we = rdy; o.pc_we = rdy;
      return o;
   endfunction
   function automatic out_t o_decode(logic ill);
      out_t o = o_st(ST_DECODE);
      o.src_b = 2'd3; o.illegal = ill;
      return o;
   endfunction
   function automatic out_t o_memaddr();
      out_t o = o_st(ST_MEM_ADDR);
      o.src_a = 1'b1; o.src_b = 2'd2;
      return o;
   endfunction
   function automatic out_t o_memrd();
      out_t o = o_st(ST_MEM_RD);
      o.mem_req = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic out_t o_memwb();
      out_t o = o_st(ST_MEM_WB);
      o.reg_write = 1'b1; o.m2r = 2'd1;
      return o;
   endfunction
   function automatic out_t o_memwr();
      out_t o = o_st(ST_MEM_WR);
      o.mem_req = 1'b1; o.mem_write = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic out_t o_rexec(logic [2:0] alu, logic ill);
      out_t o = o_st(ST_R_EXEC);
      o.src_a = 1'b1; o.alu = alu; o.illegal = ill;
      return o;
   endfunction
   function automatic out_t o_rwb();
      out_t o = o_st(ST_R_WB);
      o.reg_write = 1'b1; o.reg_dst = 2'd1;
      return o;
   endfunction
   function automatic out_t o_iexec(logic [2:0] alu);
      out_t o = o_st(ST_I_EXEC);
      o.src_a = 1'b1; o.src_b = 2'd2; o.alu = alu;
      return o;
   endfunction
   function automatic out_t o_iwb();
      out_t o = o_st(ST_I_WB);
      o.reg_write = 1'b1;
      return o;
   endfunction
   function automatic out_t o_branch(logic we);
      out_t o = o_st(ST_BRANCH);
      o.src_a = 1'b1; o.alu = 3'b001; o.pc_src = 2'd1; o.pc_we = we;
      return o;
   endfunction
   function automatic out_t o_jump();
      out_t o = o_st(ST_JUMP);
      o.pc_we = 1'b1; o.pc_src = 2'd2;
      return o;
   endfunction
   function automatic out_t o_jr();
      out_t o = o_st(ST_JR);
      o.pc_we = 1'b1; o.pc_src = 2'd3;
      return o;
   endfunction
   function automatic out_t o_jal();
      out_t o = o_st(ST_JAL);
      o.pc_we = 1'b1; o.pc_src = 2'd2; o.reg_write = 1'b1; o.reg_dst = 2'd2; o.m2r = 2'd2;
      return o;
   endfunction

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      cur_op = op; cur_fn = fn; cur_z = z;
   endtask

   // Queue one cycle of stimulus together with the control word it must produce.
   task automatic push(input logic rdy, input out_t e);
      stim_t s;
      s.rdy = rdy; s.op = cur_op; s.fn = cur_fn; s.z = cur_z;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      out_t e;
      reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      e = o_st(ST_FETCH);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
      else $display("reset_idle: state=%0d mem_req=%0d", state_o, mem_req);
      reset = 1'b0;
      @(negedge clk);
      e = o_fetch(1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL fetch_after_reset: got %h expected %h", obs, e); end
      else $display("fetch_after_reset: state=%0d mem_req=%0d", state_o, mem_req);
      reset = 1'b1;
      @(negedge clk);
      e = o_st(ST_FETCH);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_fetch: got %h expected %h", obs, e); end
      else $display("reset_mid_fetch: state=%0d mem_req=%0d", state_o, mem_req);
      reset = 1'b0;
      @(negedge clk);
      e = o_fetch(1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL refetch: got %h expected %h", obs, e); end
      else $display("refetch: state=%0d mem_req=%0d", state_o, mem_req);
      @(posedge clk);
      #1;
   endtask

   task automatic test_add;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h00, 6'h20, 1'b0);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_rexec(3'b000, 1'b0)); push(1'b1, o_rwb());
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL add cyc%0d: got %h expected %h", n, obs, e); end
         else $display("add cyc%0d: state=%0d word=%h", n, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_lw_stall;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h23, 6'h00, 1'b0);
      // ready low in DECODE/MEM_ADDR/MEM_WB must be ignored there
      push(1'b1, o_fetch(1'b1)); push(1'b0, o_decode(1'b0)); push(1'b0, o_memaddr());
      push(1'b0, o_memrd()); push(1'b0, o_memrd()); push(1'b1, o_memrd());
      push(1'b0, o_memwb());
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL lw cyc%0d: got %h expected %h", n, obs, e); end
         else $display("lw cyc%0d: state=%0d word=%h", n, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_bne;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h05, 6'h00, 1'b1);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_branch(1'b0));
      set_instr(6'h05, 6'h00, 1'b0);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_branch(1'b1));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL bne cyc%0d: got %h expected %h", n, obs, e); end
         else $display("bne cyc%0d: state=%0d word=%h", n, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_jal;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h03, 6'h15, 1'b0);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_jal());
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL jal cyc%0d: got %h expected %h", n, obs, e); end
         else $display("jal cyc%0d: state=%0d word=%h", n, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_illegal;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h3F, 6'h20, 1'b0);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b1)); push(1'b0, o_fetch(1'b0));
      set_instr(6'h00, 6'h01, 1'b0);
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_rexec(3'b000, 1'b1)); push(1'b0, o_fetch(1'b0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL illegal cyc%0d: got %h expected %h", n, obs, e); end
         else $display("illegal cyc%0d: state=%0d word=%h", n, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back;
      stim_t s; out_t e; int n = 0;
      set_instr(6'h2B, 6'h00, 1'b0);  // SW with fetch and write stalls
      push(1'b0, o_fetch(1'b0)); push(1'b1, o_fetch(1'b1)); push(1'b0, o_decode(1'b0));
      push(1'b0, o_memaddr()); push(1'b0, o_memwr()); push(1'b1, o_memwr());
      set_instr(6'h0E, 6'h00, 1'b0);  // XORI
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_iexec(3'b010)); push(1'b1, o_iwb());
      set_instr(6'h08, 6'h00, 1'b0);  // ADDI
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_iexec(3'b000)); push(1'b1, o_iwb());
      set_instr(6'h04, 6'h00, 1'b1);  // BEQ taken
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_branch(1'b1));
      set_instr(6'h04, 6'h00, 1'b0);  // BEQ not taken
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_branch(1'b0));
      set_instr(6'h02, 6'h00, 1'b0);  // J
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_jump());
      set_instr(6'h00, 6'h08, 1'b0);  // JR
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0)); push(1'b1, o_jr());
      set_instr(6'h00, 6'h22, 1'b0);  // SUB
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_rexec(3'b001, 1'b0)); push(1'b1, o_rwb());
      set_instr(6'h00, 6'h26, 1'b0);  // XOR
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_rexec(3'b010, 1'b0)); push(1'b1, o_rwb());
      set_instr(6'h00, 6'h2A, 1'b0);  // SLT
      push(1'b1, o_fetch(1'b1)); push(1'b1, o_decode(1'b0));
      push(1'b1, o_rexec(3'b011, 1'b0)); push(1'b1, o_rwb());
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front();
         mem_ready = s.rdy; opcode = s.op; funct = s.fn; zero = s.z;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL b2b cyc%0d: got %h expected %h", n, obs, e); end
         else $display("b2b cyc%0d: op=%h state=%0d word=%h", n, opcode, state_o, obs);
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      cur_op = 6'h00; cur_fn = 6'h00; cur_z = 1'b0;
      test_reset();
      test_add();
      test_lw_stall();
      test_bne();
      test_jal();
      test_illegal();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
